// File: rtl/chs_conf_encoder_if.sv
// Request/delivery bundle between a chs_conf requester and the encoder.
// Carries the power request handshake and the configuration word handshake.
// master = requester/consumer side, slave = encoder side.
interface chs_conf_encoder_if #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
);
    logic             req_valid;
    logic [PW-1:0]    req_power;
    logic             req_ready;
    logic [WIDTH-1:0] chs_conf;
    logic             conf_mode;
    logic             conf_valid;
    logic             conf_ack;
    logic             sat_err;

    modport master (
        output req_valid, req_power, conf_ack,
        input  req_ready, chs_conf, conf_mode, conf_valid, sat_err
    );

    modport slave (
        input  req_valid, req_power, conf_ack,
        output req_ready, chs_conf, conf_mode, conf_valid, sat_err
    );
endinterface

// File: rtl/chs_conf_encoder.sv
// Encodes a power level into a WIDTH-bit word with that many bits set, starting at a rotating offset.
// Latency: accept edge k -> conf_valid after edge k+WIDTH; word built one bit per cycle.
// Backpressure: req_ready low from accept until the cycle after conf_ack; conf_valid holds until acked.
module chs_conf_encoder #(
    parameter int WIDTH     = 8,
    parameter int PW        = 4,
    parameter int ROTATE_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    chs_conf_encoder_if.slave   bus
);
    localparam int LW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

    state_t           state_q,      state_d;
    logic [LW-1:0]    offset_q,     offset_d;
    logic [LW-1:0]    cnt_q,        cnt_d;
    logic [WIDTH-1:0] work_q,       work_d;
    logic [PW-1:0]    p_q,          p_d;
    logic             sat_nxt_q,    sat_nxt_d;
    logic [WIDTH-1:0] chs_conf_q,   chs_conf_d;
    logic             conf_mode_q,  conf_mode_d;
    logic             sat_err_q,    sat_err_d;
    logic             conf_valid_q, conf_valid_d;
    logic [LW-1:0]    idx;
    logic             over;

    // State and datapath registers; reset aborts any transaction and clears the offset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            offset_q     <= '0;
            cnt_q        <= '0;
            work_q       <= '0;
            p_q          <= '0;
            sat_nxt_q    <= 1'b0;
            chs_conf_q   <= '0;
            conf_mode_q  <= 1'b0;
            sat_err_q    <= 1'b0;
            conf_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            p_q          <= p_d;
            sat_nxt_q    <= sat_nxt_d;
            chs_conf_q   <= chs_conf_d;
            conf_mode_q  <= conf_mode_d;
            sat_err_q    <= sat_err_d;
            conf_valid_q <= conf_valid_d;
        end
    end

    // Next-state logic: accept in IDLE, place one bit per cycle in BUILD, wait for ack in HOLD.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        p_d          = p_q;
        sat_nxt_d    = sat_nxt_q;
        chs_conf_d   = chs_conf_q;
        conf_mode_d  = conf_mode_q;
        sat_err_d    = sat_err_q;
        conf_valid_d = conf_valid_q;
        // Index wraps naturally since WIDTH is a power of two.
        idx          = offset_q + cnt_q;
        over         = (bus.req_power > PW'(WIDTH));

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    sat_nxt_d = over;
                    p_d       = over ? PW'(WIDTH) : bus.req_power;
                    work_d    = '0;
                    cnt_d     = '0;
                    state_d   = BUILD;
                end
            end
            BUILD: begin
                // The first p positions visited from the offset are set; the rest cleared.
                work_d[idx] = (PW'(cnt_q) < p_q);
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LW'(WIDTH - 1)) begin
                    // Publish the word including the bit written this cycle.
                    chs_conf_d   = work_d;
                    conf_mode_d  = p_q[0];
                    sat_err_d    = sat_nxt_q;
                    conf_valid_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (bus.conf_ack) begin
                    conf_valid_d = 1'b0;
                    if (ROTATE_EN != 0) begin
                        offset_d = offset_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.chs_conf   = chs_conf_q;
    assign bus.conf_mode  = conf_mode_q;
    assign bus.conf_valid = conf_valid_q;
    assign bus.sat_err    = sat_err_q;
endmodule

// File: tb/tb_chs_conf_encoder.sv
// Directed bench for chs_conf_encoder: a rotating instance and a fixed-offset instance share stimulus.
// Expected words are hand-computed from power and current offset.
// All waits on the DUT are bounded by a cycle budget.
module tb_chs_conf_encoder;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    chs_conf_encoder_if #(.WIDTH(8), .PW(4)) bus0 ();
    chs_conf_encoder_if #(.WIDTH(8), .PW(4)) bus1 ();

    assign bus1.req_valid = bus0.req_valid;
    assign bus1.req_power = bus0.req_power;
    assign bus1.conf_ack  = bus0.conf_ack;

    chs_conf_encoder #(.WIDTH(8), .PW(4), .ROTATE_EN(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    chs_conf_encoder #(.WIDTH(8), .PW(4), .ROTATE_EN(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; counts edges after the accept edge until conf_valid, and whether
    // chs_conf stayed at its previous value meanwhile.
    task automatic wait_valid(input logic [7:0] prev, output int lat, output logic stable);
        lat    = 0;
        stable = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus0.conf_valid) break;
            if (bus0.chs_conf !== prev) stable = 1'b0;
        end
    endtask

    // One full transaction, starting and ending at a negedge.
    task automatic txn(input string tag, input logic [3:0] pw, input logic [7:0] exp_conf,
                       input logic exp_mode, input logic exp_sat, input int hold, input bit keep_req);
        int         lat;
        logic       stable;
        logic       hstable;
        logic [7:0] prev;
        prev = bus0.chs_conf;
        check({tag, ".rdy_idle"}, 32'(bus0.req_ready), 32'd1);
        bus0.req_valid = 1'b1;
        bus0.req_power = pw;
        @(posedge clk);
        @(negedge clk);
        if (!keep_req) bus0.req_valid = 1'b0;
        check({tag, ".rdy_busy"}, 32'(bus0.req_ready), 32'd0);
        wait_valid(prev, lat, stable);
        check({tag, ".latency"}, 32'(lat), 32'd8);
        check({tag, ".build_stable"}, 32'(stable), 32'd1);
        check({tag, ".conf"}, 32'(bus0.chs_conf), 32'(exp_conf));
        check({tag, ".mode"}, 32'(bus0.conf_mode), 32'(exp_mode));
        check({tag, ".sat"}, 32'(bus0.sat_err), 32'(exp_sat));
        check({tag, ".rdy_hold"}, 32'(bus0.req_ready), 32'd0);
        if (hold > 0) begin
            hstable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                if (bus0.conf_valid !== 1'b1 || bus0.chs_conf !== exp_conf) hstable = 1'b0;
            end
            check({tag, ".hold_stable"}, 32'(hstable), 32'd1);
        end
        bus0.conf_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.conf_ack  = 1'b0;
        bus0.req_valid = 1'b0;
        check({tag, ".valid_drop"}, 32'(bus0.conf_valid), 32'd0);
        check({tag, ".rdy_after"}, 32'(bus0.req_ready), 32'd1);
        check({tag, ".conf_kept"}, 32'(bus0.chs_conf), 32'(exp_conf));
        if (keep_req) begin
            repeat (12) begin
                @(posedge clk);
                @(negedge clk);
            end
            check({tag, ".no_extra_rdy"}, 32'(bus0.req_ready), 32'd1);
            check({tag, ".no_extra_vld"}, 32'(bus0.conf_valid), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_word;
        compared       = 0;
        mismatched     = 0;
        rst_n          = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_power = '0;
        bus0.conf_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst.conf", 32'(bus0.chs_conf), 32'h0);
        check("rst.mode", 32'(bus0.conf_mode), 32'd0);
        check("rst.valid", 32'(bus0.conf_valid), 32'd0);
        check("rst.sat", 32'(bus0.sat_err), 32'd0);
        check("rst.rdy", 32'(bus0.req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1-2: basic encode, rotation, wrap across bit 7 -> 0
        txn("t1.p3", 4'd3, 8'h07, 1'b1, 1'b0, 0, 1'b0);
        txn("t2.p3", 4'd3, 8'h0E, 1'b1, 1'b0, 0, 1'b0);
        txn("t2.p7", 4'd7, 8'hFD, 1'b1, 1'b0, 0, 1'b0);

        // 3: extremes
        do_reset();
        txn("t3.p0", 4'd0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        txn("t3.p8", 4'd8, 8'hFF, 1'b0, 1'b0, 0, 1'b0);

        // 4: saturation is per transaction (offset is 3 before p=2)
        txn("t4.p12", 4'd12, 8'hFF, 1'b0, 1'b1, 0, 1'b0);
        txn("t4.p2", 4'd2, 8'h18, 1'b0, 1'b0, 0, 1'b0);

        // 5: walking single bit with offset wrap; fixed-offset instance always 0x01
        do_reset();
        for (int i = 0; i < 9; i++) begin
            exp_word = 8'h01 << (i % 8);
            txn($sformatf("t5.walk%0d", i), 4'd1, exp_word, 1'b1, 1'b0, 0, 1'b0);
            check($sformatf("t5.fixed%0d", i), 32'(bus1.chs_conf), 32'h01);
        end

        // 6a: req_valid held high throughout; offset 1 -> bits 1,2
        txn("t6.held", 4'd2, 8'h06, 1'b0, 1'b0, 0, 1'b1);
        // 6b: ack withheld 20 cycles; offset 2 -> bits 2..6
        txn("t6.hold", 4'd5, 8'h7C, 1'b1, 1'b0, 20, 1'b0);
        // leave sat_err and chs_conf nonzero before the abort
        txn("t6.sat", 4'd15, 8'hFF, 1'b0, 1'b1, 0, 1'b0);

        // 6c: reset mid-BUILD
        bus0.req_valid = 1'b1;
        bus0.req_power = 4'd4;
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("t6.abort.conf", 32'(bus0.chs_conf), 32'h0);
        check("t6.abort.mode", 32'(bus0.conf_mode), 32'd0);
        check("t6.abort.valid", 32'(bus0.conf_valid), 32'd0);
        check("t6.abort.sat", 32'(bus0.sat_err), 32'd0);
        check("t6.abort.rdy", 32'(bus0.req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        txn("t6.after", 4'd1, 8'h01, 1'b1, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/chs_conf_encoder.md
Name: chs_conf_encoder

Overview:
Sequential encoder that turns a requested cooler/heater power level (0..WIDTH) into a WIDTH-bit chs_conf word with exactly that many bits set. It is the inverse of the popcount/parity decode of chs_conf into power and mode.
Set bits are placed starting at a rotating offset, so successive requests spread load across the element bank. The word is built one bit per cycle and delivered over a valid/ack handshake to the CoolHeatSystem configuration register.

Parameters:
WIDTH, 8, number of elements / chs_conf bits (>=2, power of 2)
PW, 4, width of req_power; must hold the value WIDTH
ROTATE_EN, 1, 1 = offset advances by 1 per completed transaction; 0 = offset fixed at 0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request strobe
req_power  input  PW  requested number of active elements
req_ready  output  1  encoder can accept a request
chs_conf  output  WIDTH  encoded configuration word (registered)
conf_mode  output  1  parity of popcount(chs_conf): heat=1 / cool=0
conf_valid  output  1  chs_conf/conf_mode/sat_err are new and awaiting ack
conf_ack  input  1  consumer has taken chs_conf
sat_err  output  1  last request exceeded WIDTH and was saturated

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset (async assert, sync release) values:
  - State IDLE.
  - chs_conf=0, conf_mode=0, conf_valid=0, sat_err=0.
  - req_ready=1, offset=0, cnt=0, work=0.
- FSM states: IDLE, BUILD, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at an edge: latch p=min(req_power,WIDTH) and sat_nxt=(req_power>WIDTH).
  - At the same edge: clear work and cnt, go to BUILD, req_ready falls.
- BUILD (exactly WIDTH cycles):
  - Each edge: idx=(offset+cnt) mod WIDTH; work[idx]=(cnt<p); cnt++.
  - On the edge writing cnt=WIDTH-1: chs_conf<=final work, conf_mode<=p[0], sat_err<=sat_nxt, conf_valid<=1, go to HOLD.
  - Latency: accept edge k -> conf_valid visible after edge k+WIDTH.
- HOLD:
  - conf_valid=1 until conf_ack=1 is sampled at an edge.
  - At that edge: conf_valid<=0; offset<=(offset+1) mod WIDTH if ROTATE_EN; go to IDLE.
  - req_ready=1 from the following cycle.
- Output stability:
  - chs_conf, conf_mode and sat_err change only on the BUILD->HOLD edge.
  - During BUILD and HOLD they hold their previous values. After ack they hold until the next completion.
- Handshake rules:
  - req_valid outside IDLE is ignored; no queueing.
  - conf_ack outside HOLD is ignored.
  - conf_valid is high for at least one full cycle.
- Invariants: popcount(chs_conf)=p and conf_mode=popcount[0] for every delivered word.
- Boundaries:
  - p=0 gives all zeros; p=WIDTH gives all ones, independent of offset.
  - Bits wrap from index WIDTH-1 to 0.
  - offset wraps WIDTH-1 -> 0.
  - sat_err is per-transaction, not sticky.
- Reset mid-BUILD or mid-HOLD aborts the transaction. All registers, including offset, return to reset values.

Test Plan:
1. Reset, request power 3, ack -> conf_valid rises 8 edges after accept; chs_conf=0x07, conf_mode=1, sat_err=0. req_ready=0 from accept until the cycle after ack.
2. After test 1, request 3 again -> chs_conf=0x0E (offset 1). Then request 7 at offset 2 -> chs_conf=0xFD, wraps bits 0 and 2..7; conf_mode=1.
3. Reset, then request 0 and then 8 -> 0x00 with conf_mode=0, then 0xFF with conf_mode=0. Offset is irrelevant for both.
4. Request 12 -> chs_conf=0xFF, sat_err=1. Next request 2 -> sat_err=0.
5. After reset, nine transactions of power 1 -> chs_conf sequence 0x01,0x02,0x04,...,0x80,0x01 (offset wrap). With ROTATE_EN=0, all nine are 0x01.
6. Protocol and reset checks:
   - req_valid held high through BUILD/HOLD -> no extra accept.
   - conf_ack withheld 20 cycles -> conf_valid and chs_conf stable.
   - rst_n low mid-BUILD -> all outputs 0, req_ready=1, next power-1 request yields 0x01.
